// File: rtl/riscvy_pkg.sv
// Shared definitions for the fetch stage: machine widths, the fetch state
// encoding and a small address-alignment helper.
package riscvy_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  // BOOT: one settling edge after reset; RUN: normal fetching;
  // HALT: terminal state after an out-of-range fetch (bound-check builds only).
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Instructions are word aligned, so a target's two low bits are dropped.
  function automatic logic [XLEN-1:0] align_inst(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage with a single-entry output register.
// The PC addresses an external combinational instruction memory; each RUN
// cycle with a free (or draining) output slot captures one word and advances
// the PC by 4. A redirect flushes the slot and reloads the PC.
// Optional feature: define FETCH_BOUND_CHECK_EN to halt with a sticky
// fetch_err when a fetch would run past the end of the MEM_BYTES memory.
module inst_fetch
  import riscvy_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int unsigned     MEM_BYTES = 88
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] inst_address,
  input  logic [ILEN-1:0] instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            fetch_err
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_target;
  logic            slot_free;
  logic            take_redirect;
  logic            want_fetch;
  logic            out_of_range;
  logic            capture;
  logic            bound_fail;
  logic            drain;

  assign inst_address    = pc;
  assign pc_inc          = pc + XLEN'(INST_BYTES);
  assign redirect_target = align_inst(redirect_pc);

`ifdef FETCH_BOUND_CHECK_EN
  // One extra bit so a PC near 2^64 cannot wrap around and look in range.
  logic [XLEN:0] pc_end;
  assign pc_end       = {1'b0, pc} + (XLEN+1)'(INST_BYTES);
  assign out_of_range = pc_end > (XLEN+1)'(MEM_BYTES);
`else
  // Without the bound check the memory size plays no role in the logic.
  logic unused_mem_bytes;
  assign unused_mem_bytes = ^MEM_BYTES;
  assign out_of_range     = 1'b0;
`endif

  // Decide what this cycle does: redirect beats capture beats stall.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    slot_free     = !out_valid || out_ready;
    take_redirect = 1'b0;
    want_fetch    = 1'b0;
    if (state == RUN) begin
      take_redirect = redirect_valid;
      want_fetch    = !redirect_valid && slot_free;
    end
    capture    = want_fetch && !out_of_range;
    bound_fail = want_fetch && out_of_range;
    // Once halting, a held instruction may still be consumed by decode.
    drain      = out_valid && out_ready && ((state == HALT) || bound_fail);
  end

  // Next-state logic for the BOOT/RUN/HALT sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = bound_fail ? HALT : RUN;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Program counter: reload on redirect, advance on each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (take_redirect) begin
      pc <= redirect_target;
    end else if (capture) begin
      pc <= pc_inc;
    end
  end

  // Output slot: load on capture, flush on redirect, empty on final drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      out_inst  <= instruction;
    end else if (take_redirect || drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (bound_fail) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a transaction-level model of the fetch
// stream is compared against the DUT on every falling edge, and directed
// scenarios pin the model with hand-computed literals.
// Build with FETCH_BOUND_CHECK_EN defined to exercise the halt path.
module tb_inst_fetch;

  localparam int MEM_BYTES = 88;
`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  inst_fetch #(.RESET_PC(64'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_address   (inst_address),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: byte array, little-endian word reads.
  logic [7:0] mem [0:MEM_BYTES-1];

  initial begin
    for (int w = 0; w < MEM_BYTES / 4; w++) begin
      logic [31:0] word;
      if (w == 0)      word = 32'h0000_0913;
      else if (w == 1) word = 32'h0000_0433;
      else             word = 32'h0040_0093 + 32'(w) * 32'h0010_1000;
      for (int b = 0; b < 4; b++) mem[4*w + b] = word[8*b +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a <= 64'(MEM_BYTES - 4)) begin
      int i;
      i = int'(a[15:0]);
      return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    end
    return 32'hBAD0_0000 | {16'h0, a[15:0]};
  endfunction

  assign instruction = mem_word(inst_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: the next address to fetch, the single held instruction
  // (identified by address; its word comes from memory), and halt/error.
  typedef struct packed {
    logic        started;
    logic        halted;
    logic        held;
    logic        err;
    logic [63:0] fetch_pc;
    logic [63:0] held_pc;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.fetch_pc = 64'h0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic redir,
                                        input logic [63:0] rpc, input logic rdy);
    model_t n;
    n = cur;
    if (!cur.started) begin
      n.started = 1'b1;
    end else if (cur.halted) begin
      if (rdy) n.held = 1'b0;
    end else if (redir) begin
      n.fetch_pc = {rpc[63:2], 2'b00};
      n.held     = 1'b0;
    end else if (cur.held && !rdy) begin
      n = cur;
    end else if (BOUND && ({1'b0, cur.fetch_pc} + 65'd4 > 65'(MEM_BYTES))) begin
      n.err    = 1'b1;
      n.halted = 1'b1;
      n.held   = 1'b0;
    end else begin
      n.held     = 1'b1;
      n.held_pc  = cur.fetch_pc;
      n.fetch_pc = cur.fetch_pc + 64'd4;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, redirect_valid, redirect_pc, out_ready);
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("m_inst_address", inst_address, m.fetch_pc);
    check("m_out_valid", {63'h0, out_valid}, {63'h0, m.held});
    if (m.held) begin
      check("m_out_pc", out_pc, m.held_pc);
      check("m_out_inst", {32'h0, out_inst}, {32'h0, mem_word(m.held_pc)});
    end else if (!rst_n) begin
      check("m_rst_out_pc", out_pc, 64'h0);
      check("m_rst_out_inst", {32'h0, out_inst}, 64'h0);
    end
    check("m_fetch_err", {63'h0, fetch_err}, {63'h0, m.err});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] last_pc;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    // Reset state.
    cyc(); cyc();
    check("rst_inst_address", inst_address, 64'h0);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_fetch_err", {63'h0, fetch_err}, 64'h0);

    // Release: BOOT edge, then first capture.
    rst_n = 1'b1;
    cyc();
    check("boot_no_valid", {63'h0, out_valid}, 64'h0);
    cyc();
    check("first_valid", {63'h0, out_valid}, 64'h1);
    check("first_pc", out_pc, 64'h0);
    check("first_inst", {32'h0, out_inst}, 64'h0000_0913);
    cyc();
    check("second_pc", out_pc, 64'h4);
    check("second_inst", {32'h0, out_inst}, 64'h0000_0433);
    cyc();
    check("third_pc", out_pc, 64'h8);

    // Stall for three cycles at out_pc=8.
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_pc", out_pc, 64'h8);
      check("stall_inst", {32'h0, out_inst}, 64'h0060_2093);
      check("stall_addr", inst_address, 64'hC);
    end
    out_ready = 1'b1;
    cyc();
    check("resume_pc", out_pc, 64'hC);

    // Redirect while decode is stalled; target is realigned.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2E;
    cyc();
    check("redir_flush", {63'h0, out_valid}, 64'h0);
    check("redir_addr", inst_address, 64'h2C);
    redirect_valid = 1'b0;
    cyc();
    check("redir_valid", {63'h0, out_valid}, 64'h1);
    check("redir_pc", out_pc, 64'h2C);
    check("redir_inst", {32'h0, out_inst}, 64'h00F0_B093);
    out_ready = 1'b1;

`ifdef FETCH_BOUND_CHECK_EN
    // Free run to the end of memory; expect halt after the word at 84.
    last_pc = 64'h0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (out_valid) last_pc = out_pc;
      if (fetch_err) break;
    end
    check("halt_reached", {63'h0, fetch_err}, 64'h1);
    check("halt_last_pc", last_pc, 64'h54);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    repeat (4) begin
      cyc();
      check("halt_no_valid", {63'h0, out_valid}, 64'h0);
      check("halt_addr", inst_address, 64'h58);
    end
    redirect_valid = 1'b0;
`else
    // Free run past the memory end: no error without the bound check.
    last_pc = 64'h0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (out_valid) last_pc = out_pc;
      if (last_pc >= 64'h60) break;
    end
    check("past_end_pc", last_pc, 64'h60);
    check("past_end_err", {63'h0, fetch_err}, 64'h0);
    // PC wrap modulo 2^64.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    check("wrap_addr", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    check("wrap_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_addr", inst_address, 64'h0);
    cyc();
    check("wrap_zero_pc", out_pc, 64'h0);
    check("wrap_err", {63'h0, fetch_err}, 64'h0);
`endif

    // Restart; a redirect presented during BOOT must be ignored.
    rst_n = 1'b0;
    cyc();
    check("rst2_err", {63'h0, fetch_err}, 64'h0);
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    check("boot_ignores_redirect", out_pc, 64'h0);
    repeat (5) cyc();
    check("run_to_20", out_pc, 64'h14);

    // Asynchronous reset during a stall at out_pc=20.
    out_ready = 1'b0;
    cyc();
    check("stall_20", out_pc, 64'h14);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {63'h0, out_valid}, 64'h0);
    check("async_pc", out_pc, 64'h0);
    check("async_inst", {32'h0, out_inst}, 64'h0);
    check("async_addr", inst_address, 64'h0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(); cyc();
    check("restart_valid", {63'h0, out_valid}, 64'h1);
    check("restart_pc", out_pc, 64'h0);
    cyc();
    check("restart_pc4", out_pc, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first byte address fetched after reset.
REQ-002 SHALL have parameter MEM_BYTES, default 88, instruction memory size in bytes.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_address  output  64  byte address to instruction memory, equal to the PC register.
REQ-006 SHALL have port instruction  input  32  little-endian word returned combinationally for inst_address.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  64  redirect target.
REQ-009 SHALL have port out_valid  output  1  out_pc/out_inst hold a fetched instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts the held instruction.
REQ-011 SHALL have port out_pc  output  64  address of the held instruction.
REQ-012 SHALL have port out_inst  output  32  held instruction word.
REQ-013 SHALL have port fetch_err  output  1  sticky out-of-range fetch flag.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT->RUN unconditionally next edge; RUN->HALT only per REQ-024; HALT exits only by reset.
REQ-015 SHALL perform no capture in BOOT or HALT; inst_address equals pc in all states.
REQ-016 In RUN, a capture SHALL occur when (!out_valid || out_ready) and !redirect_valid: out_inst<=instruction, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-017 In RUN, when out_valid && !out_ready && !redirect_valid, pc, out_pc, out_inst, out_valid SHALL hold unchanged (stall).
REQ-018 When redirect_valid=1 in RUN, it SHALL take priority over capture and stall: pc<={redirect_pc[63:2],2'b00}, out_valid<=0 (flush), no capture that cycle.
REQ-019 redirect_valid SHALL be ignored in BOOT and HALT.
REQ-020 Latency: an instruction at pc SHALL appear on out_inst the cycle after its capture edge; first out_valid=1 two edges after rst_n deasserts.
REQ-021 Sustained throughput SHALL be one instruction per cycle while out_ready=1.
REQ-022 pc+4 SHALL wrap modulo 2^64 without error when bound check is absent.

Reset
REQ-023 While rst_n=0 SHALL force state=BOOT, pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, fetch_err=0, including mid-stall or mid-redirect.

Configuration
REQ-024 With FETCH_BOUND_CHECK_EN defined, a RUN cycle whose capture would occur with pc+4 > MEM_BYTES SHALL not capture, SHALL set fetch_err<=1 and state<=HALT; out_valid may still drain via out_ready.
REQ-025 Without FETCH_BOUND_CHECK_EN, no range check SHALL exist, fetch_err SHALL be tied 0, HALT SHALL be unreachable.

Structure
REQ-026 Package riscvy_pkg SHALL hold XLEN=64, ILEN=32, INST_BYTES=4 and the fetch_state_t enum {BOOT,RUN,HALT}.
REQ-027 inst_fetch SHALL be a single module with no sub-modules; instruction memory is instantiated alongside it by the parent.

Verification
REQ-028 Reset release, out_ready=1 -> out_pc 0,4,8,... on consecutive cycles, out_inst matching memory words (0x00000913, 0x00000433, ...).
REQ-029 out_ready=0 for 3 cycles with out_valid=1 at out_pc=8 -> out_pc/out_inst/inst_address stable; resume yields out_pc=12 next.
REQ-030 redirect_valid=1, redirect_pc=0x2E while out_ready=0 -> next cycle out_valid=0, inst_address=0x2C; following cycle out_pc=0x2C.
REQ-031 FETCH_BOUND_CHECK_EN, MEM_BYTES=88, free run -> last out_pc=84, then fetch_err=1, state HALT, no further out_valid after drain.
REQ-032 rst_n pulsed low during stall at out_pc=20 -> outputs zero immediately (asynchronous), restart at RESET_PC.
